// File: rtl/cpu_mem_arbiter_pkg.sv
// Shared widths, constants and state encoding for the CPU instruction/data memory arbiter.
package cpu_mem_arbiter_pkg;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int STRB_W   = 4;
    localparam int TMR_W    = 16;
    localparam int STREAK_W = 4;

    localparam logic [DATA_W-1:0] ZERO_DATA = '0;
    localparam logic [STRB_W-1:0] ZERO_STRB = '0;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_BUS_I = 2'd1,
        ARB_BUS_D = 2'd2
    } arb_state_e;

endpackage

// File: rtl/cpu_arb_timer.sv
// Transaction watchdog: a down-counter loaded on clear, and decremented while enabled.
// It expires at terminal count. LIMIT=0 never expires.
module cpu_arb_timer
    import cpu_mem_arbiter_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam logic [TMR_W-1:0] LOAD_VAL = TMR_W'(LIMIT);

    logic [TMR_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = LOAD_VAL;
        end else if (enable_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = (LIMIT != 0) && (count_q == '0);

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Shares one valid/ready memory bus between CPU fetch and load/store ports,
// with data priority, a fetch starvation bound and a per-access timeout.
//
//   state     | meaning
//   ----------+------------------------------------------------
//   ARB_IDLE  | bus free, grant decision taken this cycle
//   ARB_BUS_I | fetch owns the bus, waiting for mem_ready/timeout
//   ARB_BUS_D | load/store owns the bus, waiting for mem_ready/timeout
module cpu_mem_arbiter
    import cpu_mem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_DATA_STREAK = 3,
    parameter int unsigned TIMEOUT_CYCLES  = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_req,
    input  logic [ADDR_W-1:0] instr_addr,
    output logic [DATA_W-1:0] instr_rdata,
    output logic              instr_ready,
    input  logic              data_req,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    input  logic [STRB_W-1:0] data_wenable,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_ready,
    output logic              mem_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [STRB_W-1:0] mem_wstrb,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              bus_error
);

    localparam logic [STREAK_W-1:0] MAX_STREAK = STREAK_W'(MAX_DATA_STREAK);

    arb_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                err_q, err_d;

    logic busy, grant_d, grant_i, expire, done, timeout;

    assign busy    = (state_q == ARB_BUS_I) || (state_q == ARB_BUS_D);
    assign grant_d = (state_q == ARB_IDLE) && data_req && (!instr_req || (streak_q < MAX_STREAK));
    assign grant_i = (state_q == ARB_IDLE) && !grant_d && instr_req;
    // mem_ready wins over a coincident expiry, so real data is never discarded
    assign done    = busy && (mem_ready || expire);
    assign timeout = busy && expire && !mem_ready;

    cpu_arb_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (grant_d || grant_i),
        .enable_i (busy && !mem_ready),
        .expire_o (expire)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (grant_d) begin
                    state_d = ARB_BUS_D;
                end else if (grant_i) begin
                    state_d = ARB_BUS_I;
                end
            end
            ARB_BUS_I, ARB_BUS_D: begin
                if (done) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        streak_d = streak_q;
        err_d    = err_q | timeout;
        if (grant_d) begin
            addr_d  = data_addr;
            wdata_d = data_wdata;
            wstrb_d = data_wenable;
            if (!instr_req) begin
                streak_d = '0;
            end else if (streak_q < MAX_STREAK) begin
                streak_d = streak_q + 1'b1;
            end
        end else if (grant_i) begin
            addr_d   = instr_addr;
            wdata_d  = ZERO_DATA;
            wstrb_d  = ZERO_STRB;
            streak_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            streak_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            streak_q <= streak_d;
            err_q    <= err_d;
        end
    end

    assign mem_valid   = busy;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign mem_wstrb   = wstrb_q;
    assign bus_error   = err_q;

    assign instr_ready = (state_q == ARB_BUS_I) && done;
    assign data_ready  = (state_q == ARB_BUS_D) && done;
    assign instr_rdata = ((state_q == ARB_BUS_I) && mem_ready) ? mem_rdata : ZERO_DATA;
    assign data_rdata  = ((state_q == ARB_BUS_D) && mem_ready) ? mem_rdata : ZERO_DATA;

endmodule
